stage3_execute_mc: RTL
======================

STAGE3_EXECUTE_MC -- requirements
Module: stage3_execute_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width (>=8).
REQ-002 SHALL have parameter REGBITS, default 4, write-back register index width.
REQ-003 SHALL have clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have rst_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have stall_i  input  1  stage-4 backpressure.
REQ-006 SHALL have stall_o  output  1  backpressure to stage 2.
REQ-007 SHALL have valid_i  input  1  stage-2 slot holds a real instruction.
REQ-008 SHALL have control_branch_i  input  3  branch mode.
REQ-009 SHALL have control_load_i and control_store_i  input  1 each  memory-op flags.
REQ-010 SHALL have aluop_i  input  4  ALU op code.
REQ-011 SHALL have mul_i  input  1  select iterative multiply instead of ALU.
REQ-012 SHALL have alu_a_i, alu_b_i, branch_test_val_i  input  WIDTH each  operands.
REQ-013 SHALL have do_wb_i  input  1 and wb_reg_i  input  REGBITS  write-back control.
REQ-014 SHALL have result_o  output  WIDTH  ALU or product result.
REQ-015 SHALL have valid_o  output  1  result_o and controls meaningful this cycle.
REQ-016 SHALL have control_load_o, control_store_o, control_take_branch_o, do_wb_o  output  1 each; wb_reg_o  output  REGBITS.

Function
REQ-017 SHALL define stall_o = stall_i OR (state == MUL), combinationally.
REQ-018 SHALL capture all *_i inputs into stage registers on an edge where stall_o == 0; otherwise hold them.
REQ-019 SHALL register control_store_i into control_store_o and control_load_i into control_load_o, independently.
REQ-020 SHALL implement FSM states IDLE and MUL; IDLE -> MUL on capture with valid_i=1 and mul_i=1; MUL -> IDLE when the iteration counter expires.
REQ-021 SHALL multiply by shift-add, one multiplier bit per cycle, occupying MUL for exactly WIDTH cycles.
REQ-022 SHALL present the low WIDTH bits of the unsigned product on result_o in the first IDLE cycle after MUL.
REQ-023 SHALL present, in IDLE for non-multiply ops, result_o = ALU(aluop, a, b) from stage registers, combinational from registers, 0-cycle added latency.
REQ-024 SHALL drive valid_o = captured valid AND state == IDLE; valid_o SHALL be 0 throughout MUL.
REQ-025 SHALL continue multiply iterations while stall_i is high; the finished result SHALL be held in IDLE until stall_i falls and a new capture occurs.
REQ-026 SHALL evaluate branch modes: 000 never, 001 always, 010 test!=0, 011 test==0, 100 test[WIDTH-1]==1, 101 test[WIDTH-1]==0, 110/111 never.
REQ-027 SHALL drive control_take_branch_o = valid_o AND branch condition.
REQ-028 SHALL ignore mul_i when valid_i=0 (no MUL entry).

Reset
REQ-029 SHALL, with rst_i high at an edge, take precedence over capture and force state IDLE, counter 0, all stage registers 0, branch mode 000.
REQ-030 SHALL, after reset, output valid_o=0, result_o=0, all control outputs 0, wb_reg_o=0, stall_o=stall_i.
REQ-031 SHALL abandon any multiply in progress when reset asserts mid-operation; no partial product appears afterwards.

Structure
REQ-032 SHALL take branch-mode encodings (CONTROL_BRANCH_*, 3 bits) and ALU op codes from the shared defines file, not local literals.
REQ-033 SHALL instantiate one sub-module, alu, parametrised by WIDTH; multiplier and FSM stay in this module.

Verification
REQ-034 SHALL test: valid_i=1, aluop ADD, a=5, b=7 -> next cycle result_o=12, valid_o=1, stall_o=0.
REQ-035 SHALL test: mul_i=1, a=0x0001_0003, b=0x0000_0010 -> stall_o high 32 cycles, valid_o low, then result_o=0x0010_0030, valid_o=1.
REQ-036 SHALL test: branch mode 100 with test=0x8000_0000 -> take_branch=1; mode 101 same value -> 0; mode 110 -> 0; valid_i=0 -> 0.
REQ-037 SHALL test: stall_i high during MUL and 3 cycles beyond -> product still correct, held stable, no new capture until stall_i low.
REQ-038 SHALL test: rst_i asserted at MUL cycle 10 -> next cycle state IDLE, valid_o=0, result_o=0, stall_o=stall_i.
REQ-039 SHALL test: control_load_i=1, control_store_i=0 captured -> control_load_o=1, control_store_o=0.

Source files
------------

// File: rtl/stage3_execute_mc_pkg.sv
// ----------------------------------------------------------------------------
// stage3_execute_mc_pkg
// Shared definitions for the execute stage: branch-mode encodings, ALU op
// codes, the execute FSM state type and the branch-condition helper.
// No ports (package).
// ----------------------------------------------------------------------------
package stage3_execute_mc_pkg;

   // Branch-mode encodings carried on control_branch
   localparam logic [2:0] CONTROL_BRANCH_NEVER  = 3'b000;
   localparam logic [2:0] CONTROL_BRANCH_ALWAYS = 3'b001;
   localparam logic [2:0] CONTROL_BRANCH_NZ     = 3'b010;
   localparam logic [2:0] CONTROL_BRANCH_Z      = 3'b011;
   localparam logic [2:0] CONTROL_BRANCH_NEG    = 3'b100;
   localparam logic [2:0] CONTROL_BRANCH_NNEG   = 3'b101;

   // ALU op codes
   localparam logic [3:0] ALUOP_ADD   = 4'd0;
   localparam logic [3:0] ALUOP_SUB   = 4'd1;
   localparam logic [3:0] ALUOP_AND   = 4'd2;
   localparam logic [3:0] ALUOP_OR    = 4'd3;
   localparam logic [3:0] ALUOP_XOR   = 4'd4;
   localparam logic [3:0] ALUOP_SLL   = 4'd5;
   localparam logic [3:0] ALUOP_SRL   = 4'd6;
   localparam logic [3:0] ALUOP_SRA   = 4'd7;
   localparam logic [3:0] ALUOP_SLT   = 4'd8;
   localparam logic [3:0] ALUOP_SLTU  = 4'd9;
   localparam logic [3:0] ALUOP_PASSB = 4'd10;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_e;

   // Branch condition from the mode and two summary bits of the test value;
   // reserved modes (110/111) never branch.
   function automatic logic branch_cond(input logic [2:0] mode,
                                        input logic       is_zero,
                                        input logic       sign);
      logic take;
      take = 1'b0;
      case (mode)
         CONTROL_BRANCH_NEVER:  take = 1'b0;
         CONTROL_BRANCH_ALWAYS: take = 1'b1;
         CONTROL_BRANCH_NZ:     take = ~is_zero;
         CONTROL_BRANCH_Z:      take = is_zero;
         CONTROL_BRANCH_NEG:    take = sign;
         CONTROL_BRANCH_NNEG:   take = ~sign;
         default:               take = 1'b0;
      endcase
      return take;
   endfunction

endpackage

// File: rtl/stage3_execute_mc_alu.sv
// ----------------------------------------------------------------------------
// stage3_execute_mc_alu
// Purely combinational ALU used by the execute stage.
// Ports:
//   op_i      [3:0]        ALU op code (ALUOP_*)
//   a_i, b_i  [WIDTH-1:0]  operands; shifts use the low log2(WIDTH) bits of b
//   result_o  [WIDTH-1:0]  result; unknown op codes give 0
// ----------------------------------------------------------------------------
module stage3_execute_mc_alu
   import stage3_execute_mc_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [3:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] result_o
);

   localparam int SHW = $clog2(WIDTH);

   logic [SHW-1:0] sh_s;
   assign sh_s = b_i[SHW-1:0];

   // Op decode
   always_comb begin
      result_o = '0;
      case (op_i)
         ALUOP_ADD:   result_o = a_i + b_i;
         ALUOP_SUB:   result_o = a_i - b_i;
         ALUOP_AND:   result_o = a_i & b_i;
         ALUOP_OR:    result_o = a_i | b_i;
         ALUOP_XOR:   result_o = a_i ^ b_i;
         ALUOP_SLL:   result_o = a_i << sh_s;
         ALUOP_SRL:   result_o = a_i >> sh_s;
         ALUOP_SRA:   result_o = $signed(a_i) >>> sh_s;
         ALUOP_SLT:   result_o[0] = ($signed(a_i) < $signed(b_i));
         ALUOP_SLTU:  result_o[0] = (a_i < b_i);
         ALUOP_PASSB: result_o = b_i;
         default:     result_o = '0;
      endcase
   end

endmodule

// File: rtl/stage3_execute_mc.sv
// ----------------------------------------------------------------------------
// stage3_execute_mc
// Pipeline execute stage with a single-cycle ALU and an iterative shift-add
// multiplier (one multiplier bit per cycle, WIDTH cycles). While multiplying,
// the stage back-pressures stage 2 through stall_o.
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   stall_i / stall_o          backpressure from stage 4 / to stage 2
//   valid_i                    stage-2 slot holds a real instruction
//   control_branch_i [2:0]     branch mode (CONTROL_BRANCH_*)
//   control_load_i/_store_i    memory-op flags
//   aluop_i [3:0], mul_i       ALU op, select multiply
//   alu_a_i, alu_b_i           operands; branch_test_val_i branch test value
//   do_wb_i, wb_reg_i          write-back control
//   result_o, valid_o          result and its qualifier
//   control_*_o, do_wb_o,
//   wb_reg_o                   registered controls, take_branch qualified
// ----------------------------------------------------------------------------
module stage3_execute_mc
   import stage3_execute_mc_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int REGBITS = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               stall_i,
   output logic               stall_o,
   input  logic               valid_i,
   input  logic [2:0]         control_branch_i,
   input  logic               control_load_i,
   input  logic               control_store_i,
   input  logic [3:0]         aluop_i,
   input  logic               mul_i,
   input  logic [WIDTH-1:0]   alu_a_i,
   input  logic [WIDTH-1:0]   alu_b_i,
   input  logic [WIDTH-1:0]   branch_test_val_i,
   input  logic               do_wb_i,
   input  logic [REGBITS-1:0] wb_reg_i,
   output logic [WIDTH-1:0]   result_o,
   output logic               valid_o,
   output logic               control_load_o,
   output logic               control_store_o,
   output logic               control_take_branch_o,
   output logic               do_wb_o,
   output logic [REGBITS-1:0] wb_reg_o
);

   localparam int CNTW = $clog2(WIDTH + 1);
   localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(WIDTH);
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(1);

   state_e state_q, state_d;

   // Stage registers
   logic               valid_q;
   logic               mul_q;
   logic [2:0]         branch_q;
   logic               load_q;
   logic               store_q;
   logic [3:0]         aluop_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH-1:0]   test_q;
   logic               do_wb_q;
   logic [REGBITS-1:0] wb_reg_q;

   // Multiplier state
   logic [CNTW-1:0]    cnt_q;
   logic [WIDTH-1:0]   acc_q;
   logic [WIDTH-1:0]   mcand_q;
   logic [WIDTH-1:0]   mplier_q;

   logic               capture_s;
   logic               mul_start_s;
   logic [WIDTH-1:0]   alu_res_s;

   assign stall_o     = stall_i | (state_q == ST_MUL);
   assign capture_s   = ~stall_o;
   // mul_i on an empty slot must not start a multiply
   assign mul_start_s = capture_s & valid_i & mul_i;

   // FSM state register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (mul_start_s) begin
               state_d = ST_MUL;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_MUL: begin
            if (cnt_q == CNT_LAST) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_MUL;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Stage registers: capture whenever the stage is not stalled
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q  <= 1'b0;
         mul_q    <= 1'b0;
         branch_q <= CONTROL_BRANCH_NEVER;
         load_q   <= 1'b0;
         store_q  <= 1'b0;
         aluop_q  <= 4'd0;
         a_q      <= '0;
         b_q      <= '0;
         test_q   <= '0;
         do_wb_q  <= 1'b0;
         wb_reg_q <= '0;
      end else if (capture_s) begin
         valid_q  <= valid_i;
         mul_q    <= valid_i & mul_i;
         branch_q <= control_branch_i;
         load_q   <= control_load_i;
         store_q  <= control_store_i;
         aluop_q  <= aluop_i;
         a_q      <= alu_a_i;
         b_q      <= alu_b_i;
         test_q   <= branch_test_val_i;
         do_wb_q  <= do_wb_i;
         wb_reg_q <= wb_reg_i;
      end
   end

   // Shift-add multiplier: multiplicand shifts left, multiplier shifts right,
   // one partial product accumulated per MUL cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
      end else if (mul_start_s) begin
         cnt_q    <= CNT_LOAD;
         acc_q    <= '0;
         mcand_q  <= alu_a_i;
         mplier_q <= alu_b_i;
      end else if (state_q == ST_MUL) begin
         cnt_q    <= cnt_q - CNT_LAST;
         acc_q    <= mplier_q[0] ? (acc_q + mcand_q) : acc_q;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
      end
   end

   stage3_execute_mc_alu #(
      .WIDTH (WIDTH)
   ) u_alu (
      .op_i     (aluop_q),
      .a_i      (a_q),
      .b_i      (b_q),
      .result_o (alu_res_s)
   );

   // acc_q holds the finished product once the FSM is back in IDLE and stays
   // there until the next capture replaces mul_q.
   assign result_o              = mul_q ? acc_q : alu_res_s;
   assign valid_o               = valid_q & (state_q == ST_IDLE);
   assign control_load_o        = load_q;
   assign control_store_o       = store_q;
   assign control_take_branch_o = valid_o &
                                  branch_cond(branch_q, (test_q == '0), test_q[WIDTH-1]);
   assign do_wb_o               = do_wb_q;
   assign wb_reg_o              = wb_reg_q;

endmodule
